div_40_8: RTL and testbench
===========================

DIV_40_8 -- requirements
Module: div_40_8

Interface
REQ-001 Parameter WIDTHN, 40, dividend width (signed).
REQ-002 Parameter WIDTHD, 8, divisor and remainder width (signed).
REQ-003 Parameter WIDTHQ, 32, quotient width (signed).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clock and reset are the only clock/reset ports.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  request; sampled only in IDLE.
REQ-008 dividend  in  WIDTHN  signed numerator, captured with start.
REQ-009 divisor  in  WIDTHD  signed denominator, captured with start.
REQ-010 busy  out  1  high from cycle after accepted start until valid cycle inclusive.
REQ-011 valid  out  1  one-cycle result strobe.
REQ-012 quotient  out  WIDTHQ  signed quotient, truncated toward zero.
REQ-013 remainder  out  WIDTHD  signed remainder, sign of dividend.
REQ-014 div_by_zero  out  1  qualified by valid.
REQ-015 overflow  out  1  quotient saturated; qualified by valid.

Function
REQ-016 The block SHALL implement states IDLE, CALC, SIGN, DONE; IDLE->CALC on start, CALC->SIGN after WIDTHN iterations, SIGN->DONE, DONE->IDLE unconditionally.
REQ-017 On accepted start, the block SHALL latch the dividend/divisor magnitudes (WIDTHN/WIDTHD-bit unsigned) and the sign bits; -2^39 and -128 SHALL convert exactly.
REQ-018 CALC SHALL perform one restoring shift-subtract step per clock, MSB first, for exactly 40 cycles.
REQ-019 SIGN SHALL apply the negation rules: quotient negative iff operand signs differ; remainder negative iff dividend negative.
REQ-020 With start sampled at cycle t, valid SHALL be high in cycle t+42 only (fixed latency, including error cases).
REQ-021 If the signed result lies outside [-2^31, 2^31-1], quotient SHALL saturate (0x7FFFFFFF positive, 0x80000000 negative) with overflow=1 and remainder=0.
REQ-022 If divisor=0, div_by_zero=1, overflow=0, remainder=0, quotient=0x7FFFFFFF for dividend>=0, else 0x80000000.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 start in the DONE cycle SHALL be ignored; start in the following cycle SHALL be accepted.
REQ-025 quotient/remainder/flags SHALL hold their last values until the next valid.

Reset
REQ-026 Reset SHALL force IDLE, busy=0, valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0.
REQ-027 Reset mid-operation SHALL abort the computation with no valid pulse; start SHALL be accepted the cycle after reset deasserts.

Structure
REQ-028 Package div_40_8_pkg SHALL hold the state enum, the WIDTH defaults, and the saturation constants QMAX/QMIN.
REQ-029 Sub-module div_restore_step (combinational: partial remainder, dividend bit, divisor magnitude -> new partial remainder, quotient bit) SHALL be instantiated once.

Verification
REQ-030 1000 / 7 -> valid at t+42, quotient=142, remainder=6, flags 0.
REQ-031 -1000 / 7 -> quotient=-142, remainder=-6; 1000 / -7 -> quotient=-142, remainder=6.
REQ-032 -2^39 / -128 -> quotient=0x7FFFFFFF, remainder=0, overflow=1; 2^38 / 1 -> 0x7FFFFFFF, overflow=1.
REQ-033 123 / 0 -> quotient=0x7FFFFFFF, div_by_zero=1; -5 / 0 -> 0x80000000, div_by_zero=1.
REQ-034 Second start at t+10 -> ignored, single valid at t+42; reset at t+20 -> no valid, all outputs 0, new start at t+22 -> valid at t+64.

Source files
------------

// File: rtl/div_40_8_pkg.sv
// Shared widths, saturation constants and FSM states for the 40/8 signed divider.
package div_40_8_pkg;

    localparam int unsigned DEF_WIDTHN = 40;
    localparam int unsigned DEF_WIDTHD = 8;
    localparam int unsigned DEF_WIDTHQ = 32;

    localparam logic [DEF_WIDTHQ-1:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [DEF_WIDTHQ-1:0] QMIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_40_8_restore_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_restore_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] part,
    input  logic         num_bit,
    input  logic [W-1:0] dmag,
    output logic [W-1:0] part_next_c,
    output logic         qbit_c
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         borrow;

    // Partial remainder stays below dmag, so the W-bit difference is exact when no borrow.
    assign shifted     = {part, num_bit};
    assign borrow      = shifted < {1'b0, dmag};
    assign diff        = shifted[W-1:0] - dmag;
    assign qbit_c      = ~borrow;
    assign part_next_c = borrow ? shifted[W-1:0] : diff;

endmodule

// File: rtl/div_40_8.sv
// Fixed-latency signed 40/8 divider: magnitude restoring division, then sign fix-up and saturation.
module div_40_8
    import div_40_8_pkg::*;
#(
    parameter int unsigned WIDTHN = DEF_WIDTHN,
    parameter int unsigned WIDTHD = DEF_WIDTHD,
    parameter int unsigned WIDTHQ = DEF_WIDTHQ
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [WIDTHN-1:0] dividend,
    input  logic signed [WIDTHD-1:0] divisor,
    output logic                     busy,
    output logic                     valid,
    output logic signed [WIDTHQ-1:0] quotient,
    output logic signed [WIDTHD-1:0] remainder,
    output logic                     div_by_zero,
    output logic                     overflow
);

    localparam int unsigned       CW   = $clog2(WIDTHN);
    localparam logic [CW-1:0]     LAST = CW'(WIDTHN - 1);
    localparam logic [WIDTHN-1:0] QLIM = WIDTHN'(1) << (WIDTHQ - 1);

    state_t            state, state_next;
    logic [WIDTHN-1:0] num;
    logic [WIDTHD-1:0] part, dmag, part_next;
    logic              sign_n, sign_d, qbit;
    logic [CW-1:0]     iter;

    logic              q_neg, q_ovf, d_zero;
    logic [WIDTHQ-1:0] q_mag, q_res;
    logic [WIDTHD-1:0] r_res;

    div_restore_step #(.W(WIDTHD)) u_step (
        .part        (part),
        .num_bit     (num[WIDTHN-1]),
        .dmag        (dmag),
        .part_next_c (part_next),
        .qbit_c      (qbit)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (iter == LAST) state_next = SIGN;
            SIGN:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Signed result with divide-by-zero and saturation overrides
    always_comb begin
        q_neg  = sign_n ^ sign_d;
        d_zero = (dmag == '0);
        q_mag  = num[WIDTHQ-1:0];
        q_ovf  = q_neg ? (num > QLIM) : (num >= QLIM);
        q_res  = q_neg ? -q_mag : q_mag;
        r_res  = sign_n ? -part : part;
        if (d_zero) begin
            q_res = sign_n ? WIDTHQ'(QMIN) : WIDTHQ'(QMAX);
            r_res = '0;
            q_ovf = 1'b0;
        end else if (q_ovf) begin
            q_res = q_neg ? WIDTHQ'(QMIN) : WIDTHQ'(QMAX);
            r_res = '0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= 1'b0;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            num         <= '0;
            part        <= '0;
            dmag        <= '0;
            sign_n      <= 1'b0;
            sign_d      <= 1'b0;
            iter        <= '0;
        end else begin
            busy  <= (state_next != IDLE);
            valid <= (state_next == DONE);
            case (state)
                IDLE: if (start) begin
                    num    <= dividend[WIDTHN-1] ? WIDTHN'(-dividend) : WIDTHN'(dividend);
                    dmag   <= divisor[WIDTHD-1] ? WIDTHD'(-divisor) : WIDTHD'(divisor);
                    sign_n <= dividend[WIDTHN-1];
                    sign_d <= divisor[WIDTHD-1];
                    part   <= '0;
                    iter   <= '0;
                end
                CALC: begin
                    num  <= {num[WIDTHN-2:0], qbit};
                    part <= part_next;
                    iter <= (iter == LAST) ? '0 : iter + CW'(1);
                end
                SIGN: begin
                    quotient    <= q_res;
                    remainder   <= r_res;
                    div_by_zero <= d_zero;
                    overflow    <= q_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_40_8.sv
// Bench for div_40_8: vector table, random ops against a reference model, and timing corner sequences.
module tb_div_40_8;

    logic               clock = 1'b0;
    logic               reset, start;
    logic signed [39:0] dividend;
    logic signed [7:0]  divisor;
    logic               busy, valid, div_by_zero, overflow;
    logic [31:0]        quotient;
    logic [7:0]         remainder;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          at;
    } exp_t;

    typedef struct {
        logic signed [39:0] n;
        logic signed [7:0]  d;
        logic [31:0]        q;
        logic [7:0]         r;
        logic               dbz;
        logic               ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    div_40_8 dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: host signed division truncates toward zero, remainder takes dividend sign.
    function automatic exp_t model(input logic signed [39:0] n, input logic signed [7:0] d);
        longint ln, ld, q, r;
        exp_t   e;
        ln = longint'(n);
        ld = longint'(d);
        e.at = 0; e.dbz = 1'b0; e.ovf = 1'b0; e.q = '0; e.r = '0;
        if (ld == 0) begin
            e.dbz = 1'b1;
            e.q   = (ln < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            q = ln / ld;
            r = ln % ld;
            if (q > 64'sd2147483647) begin
                e.ovf = 1'b1; e.q = 32'h7FFF_FFFF;
            end else if (q < -64'sd2147483648) begin
                e.ovf = 1'b1; e.q = 32'h8000_0000;
            end else begin
                e.q = 32'(q); e.r = 8'(r);
            end
        end
        return e;
    endfunction

    // Scoreboard: every valid pops one expectation, including its arrival cycle.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got valid=1 want none pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.at));
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    // Called on a negedge; holds start for one cycle and expects valid 42 cycles later.
    task automatic issue(input logic signed [39:0] n, input logic signed [7:0] d, input exp_t e);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        e.at     = cyc + 42;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_quotient"}, 64'(quotient), 64'd0);
        check({tag, "_remainder"}, 64'(remainder), 64'd0);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t               e;
        int                 c0;
        logic signed [39:0] rn;
        logic signed [7:0]  rd;

        tbl.push_back('{ 40'sd1000,        8'sd7,    32'd142,       8'd6,  1'b0, 1'b0});
        tbl.push_back('{-40'sd1000,        8'sd7,    32'hFFFF_FF72, 8'hFA, 1'b0, 1'b0});
        tbl.push_back('{ 40'sd1000,       -8'sd7,    32'hFFFF_FF72, 8'h06, 1'b0, 1'b0});
        tbl.push_back('{ 40'h80_0000_0000, 8'h80,    32'h7FFF_FFFF, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{ 40'h40_0000_0000, 8'sd1,    32'h7FFF_FFFF, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{ 40'sd123,         8'sd0,    32'h7FFF_FFFF, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{-40'sd5,           8'sd0,    32'h8000_0000, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{ 40'h80_0000_0000, 8'sd0,    32'h8000_0000, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{ 40'sd0,           8'sd5,    32'h0000_0000, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{ 40'hFF_8000_0000, 8'sd1,    32'h8000_0000, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{ 40'h00_8000_0000, 8'sd1,    32'h7FFF_FFFF, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{ 40'h00_8000_0000, 8'hFF,    32'h8000_0000, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{ 40'sd1000,        8'h80,    32'hFFFF_FFF9, 8'h68, 1'b0, 1'b0});
        tbl.push_back('{-40'sd127,         8'h80,    32'h0000_0000, 8'h81, 1'b0, 1'b0});
        tbl.push_back('{ 40'h80_0000_0000, 8'sd127,  32'h8000_0000, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{ 40'h7F_FFFF_FFFF, 8'h80,    32'h8000_0000, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{ 40'h3F_7FFF_FF86, 8'sd127,  32'h7FFF_FFFF, 8'h05, 1'b0, 1'b0});
        tbl.push_back('{ 40'hC0_8000_0000, 8'sd127,  32'h8000_0000, 8'h00, 1'b0, 1'b0});

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        foreach (tbl[i]) begin
            e.q = tbl[i].q; e.r = tbl[i].r; e.dbz = tbl[i].dbz; e.ovf = tbl[i].ovf; e.at = 0;
            issue(tbl[i].n, tbl[i].d, e);
            drain();
        end

        // Results hold until the next valid.
        repeat (5) @(negedge clock);
        check("hold_quotient", 64'(quotient), 64'(tbl[tbl.size()-1].q));
        check("hold_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rn = 40'({$urandom(), $urandom()});
            rn = rn >>> $urandom_range(0, 16);
            rd = (i % 6 == 0) ? 8'sd0 : 8'($urandom());
            issue(rn, rd, model(rn, rd));
            drain();
        end

        // Start while busy is ignored.
        c0 = cyc;
        issue(40'sd1000, 8'sd7, model(40'sd1000, 8'sd7));
        check("busy_after_start", 64'(busy), 64'd1);
        while (cyc < c0 + 10) @(negedge clock);
        dividend = -40'sd5; divisor = 8'sd3; start = 1'b1;
        check("busy_mid", 64'(busy), 64'd1);
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (15) @(negedge clock);
        check("busy_idle", 64'(busy), 64'd0);

        // Start in DONE is ignored; start on the following cycle is accepted.
        c0 = cyc;
        issue(40'sd2000, 8'sd9, model(40'sd2000, 8'sd9));
        while (cyc < c0 + 42) @(negedge clock);
        dividend = 40'sd77; divisor = 8'sd5; start = 1'b1;
        check("busy_done", 64'(busy), 64'd1);
        @(negedge clock);
        check("busy_after_done", 64'(busy), 64'd0);
        issue(40'sd300, -8'sd7, model(40'sd300, -8'sd7));
        check("busy_reaccept", 64'(busy), 64'd1);
        drain();
        repeat (5) @(negedge clock);

        // Reset mid-operation aborts; restart two cycles later.
        c0 = cyc;
        issue(40'sd1000, 8'sd7, model(40'sd1000, 8'sd7));
        while (cyc < c0 + 20) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        check_zero_outputs("midreset");
        while (cyc < c0 + 22) @(negedge clock);
        issue(-40'sd1000, 8'sd7, model(-40'sd1000, 8'sd7));
        drain();

        repeat (50) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
